// File: rtl/window3x3_gen.sv
// window3x3_gen: streaming 3x3 neighbourhood generator for raster-order
// 8-bit greyscale pixels. Two line buffers (lb_a = previous row,
// lb_b = row before that) plus a 3x3 shift register give one registered
// window per valid pixel, one cycle after the pixel that completes it.
// Optional feature macro: WIN_COORD_EN adds registered centre coordinates
// (win_x, win_y) aligned with the window.
module window3x3_gen #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                pix_in,
  input  logic                      pix_valid,
  input  logic                      frame_start,
  output logic [7:0]                z0,
  output logic [7:0]                z1,
  output logic [7:0]                z2,
  output logic [7:0]                z3,
  output logic [7:0]                z4,
  output logic [7:0]                z5,
  output logic [7:0]                z6,
  output logic [7:0]                z7,
  output logic [7:0]                z8,
  output logic                      win_valid
`ifdef WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0]  win_x,
  output logic [$clog2(IMG_H)-1:0]  win_y
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [7:0]    lb_a_q [IMG_W];
  logic [7:0]    lb_b_q [IMG_W];
  logic [7:0]    lb_a_rd, lb_b_rd;
  logic [7:0]    win_q [9];
  logic [7:0]    win_d [9];
  logic          win_valid_q, win_valid_d;

  // Position of the incoming pixel; frame_start forces it to (0,0) in the same cycle.
  always_comb begin
    if (frame_start) begin
      col_cur = {CW{1'b0}};
      row_cur = {RW{1'b0}};
    end else begin
      col_cur = col_q;
      row_cur = row_q;
    end
  end

  // Read-before-write: the line buffers are read at the current column
  // and the old contents feed both the window and the lb_a -> lb_b copy.
  assign lb_a_rd = lb_a_q[col_cur];
  assign lb_b_rd = lb_b_q[col_cur];

  // Column/row counter next state: advance on valid pixels, wrap at line and frame ends.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (row_cur == ROW_LAST) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_cur + RW'(1);
        end
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end else if (frame_start) begin
      col_d = {CW{1'b0}};
      row_d = {RW{1'b0}};
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Window next state: shift columns left and append the new right column on a valid pixel.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    win_valid_d = 1'b0;
    if (pix_valid) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb_b_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb_a_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      // Two fresh columns and two buffered rows are guaranteed from (2,2) on,
      // so stale data from a previous line or abandoned frame is never flagged.
      win_valid_d = (col_cur >= CW'(2)) && (row_cur >= RW'(2));
    end else begin
      win_valid_d = 1'b0;
    end
  end

  // Counter, window and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      win_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= 8'd0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Line buffers: plain RAM without reset; contents are masked by the valid gating.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_b_q[col_cur] <= lb_a_rd;
      lb_a_q[col_cur] <= pix_in;
    end
  end

`ifdef WIN_COORD_EN
  logic [CW-1:0] win_x_q;
  logic [RW-1:0] win_y_q;

  // Centre coordinates of the window being formed, registered with the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x_q <= {CW{1'b0}};
      win_y_q <= {RW{1'b0}};
    end else if (pix_valid) begin
      win_x_q <= col_cur - CW'(1);
      win_y_q <= row_cur - RW'(1);
    end else begin
      win_x_q <= win_x_q;
      win_y_q <= win_y_q;
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

  assign z0        = win_q[0];
  assign z1        = win_q[1];
  assign z2        = win_q[2];
  assign z3        = win_q[3];
  assign z4        = win_q[4];
  assign z5        = win_q[5];
  assign z6        = win_q[6];
  assign z7        = win_q[7];
  assign z8        = win_q[8];
  assign win_valid = win_valid_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen with a 4x4 image, pixel = 16*row+col.
// Stimulus pushes the expected window whenever it drives a completing pixel;
// an independent monitor pops and compares on every win_valid.
module tb_window3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct packed {
    logic [71:0] z;
    logic [7:0]  x;
    logic [7:0]  y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix_in = 8'd0;
  logic       pix_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic       win_valid;
`ifdef WIN_COORD_EN
  logic [1:0] win_x, win_y;
`endif

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  window3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .frame_start(frame_start),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8),
    .win_valid(win_valid)
`ifdef WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle; a valid pixel at col>=2,row>=2 completes the window centred at (c-1,r-1).
  task automatic step(input logic v, input logic fs, input int c, input int r);
    exp_t e;
    pix_valid   = v;
    frame_start = fs;
    pix_in      = 8'(16 * r + c);
    if (v && c >= 2 && r >= 2) begin
      for (int k = 0; k < 9; k++) begin
        e.z[71 - 8*k -: 8] = 8'(16 * (r - 2 + k / 3) + (c - 2 + k % 3));
      end
      e.x = 8'(c - 1);
      e.y = 8'(r - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Full frame; gap inserts an invalid cycle after every pixel.
  task automatic frame(input logic gap, input logic fs_first);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, fs_first && r == 0 && c == 0, c, r);
        if (gap) step(1'b0, 1'b0, 0, 0);
      end
    end
  endtask

  // Rows 0,1 and pixels (0,2),(1,2): none of these completes a window.
  task automatic partial_frame();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 2 || c < 2) step(1'b1, 1'b0, c, r);
      end
    end
  endtask

  // Monitor: compare on win_valid, check zeros in reset and hold after invalid cycles.
  initial begin : monitor
    logic [71:0] cur, prev;
    logic        pv, have_prev;
    exp_t        e;
    have_prev = 1'b0;
    prev      = 72'd0;
    forever begin
      @(posedge clk);
      pv = pix_valid;
      @(negedge clk);
      cur = {z0, z1, z2, z3, z4, z5, z6, z7, z8};
      if (!rst_n) begin
        vectors++;
        if (cur != 72'd0 || win_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_zero: got z=%h valid=%b, want all zero", cur, win_valid);
        end
`ifdef WIN_COORD_EN
        vectors++;
        if (win_x !== 2'd0 || win_y !== 2'd0) begin
          errors++;
          $display("FAIL reset_coord: got x=%0d y=%0d, want 0 0", win_x, win_y);
        end
`endif
      end else if (!pv) begin
        vectors++;
        if (win_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_after_idle: got win_valid=%b, want 0", win_valid);
        end
        if (have_prev) begin
          vectors++;
          if (cur !== prev) begin
            errors++;
            $display("FAIL z_hold: got z=%h, want %h", cur, prev);
          end
        end
      end else if (win_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got z=%h, want no window", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.z) begin
            errors++;
            $display("FAIL window(%0d,%0d): got z=%h, want %h", e.x, e.y, cur, e.z);
          end
`ifdef WIN_COORD_EN
          vectors++;
          if ({6'd0, win_x} !== e.x || {6'd0, win_y} !== e.y) begin
            errors++;
            $display("FAIL coord: got (%0d,%0d), want (%0d,%0d)", win_x, win_y, e.x, e.y);
          end
`endif
        end
      end
      prev      = cur;
      have_prev = 1'b1;
    end
  end

  // Queue must be drained: every expected window was delivered.
  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d windows outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 0, 0);

    // Continuous full frame, frame_start together with the first pixel.
    frame(1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 0);
    check_drained("full_frame");

    // Same frame with an idle cycle after every pixel.
    frame(1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 0);
    check_drained("gapped_frame");

    // frame_start alone after pixel (1,2), then a fresh frame.
    partial_frame();
    step(1'b0, 1'b1, 0, 0);
    frame(1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0);
    check_drained("frame_start_abandon");

    // One-cycle reset mid-frame, then a full frame.
    partial_frame();
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0);
    check_drained("reset_mid_frame");

    // Two frames back to back with no frame_start (row wrap).
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 0, 0);
    check_drained("two_frames_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
